// File: rtl/sockit_spi_pkg.sv
// sockit_spi_pkg: shared types for the sockit SPI slave endpoint.
// Revision 1.0
`default_nettype none

package sockit_spi_pkg;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb;
  } slv_cfg_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } slv_state_t;

endpackage

`default_nettype wire

// File: rtl/sockit_spi_syn.sv
// sockit_spi_syn: SYN-stage synchronizer with rise/fall detection on the synchronized level.
// Revision 1.0
`default_nettype none

module sockit_spi_syn #(
  parameter int SYN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYN-1:0] sync_q;
  logic           dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYN-2:0], d_i};
      dly_q  <= sync_q[SYN-1];
    end
  end

  assign rise_o =  sync_q[SYN-1] & ~dly_q;
  assign fall_o = ~sync_q[SYN-1] &  dly_q;

endmodule

`default_nettype wire

// File: rtl/sockit_spi_slv.sv
// sockit_spi_slv: oversampling SPI slave with valid/ready receive and transmit word streams.
// Revision 1.0
`default_nettype none

module sockit_spi_slv
  import sockit_spi_pkg::*;
#(
  parameter int SDW = 8,
  parameter int SYN = 2,
  parameter int SDL = $clog2(SDW)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_cpol,
  input  logic           cfg_cpha,
  input  logic           cfg_lsb,
  input  logic           tx_vld,
  input  logic [SDW-1:0] tx_dat,
  output logic           tx_rdy,
  output logic           rx_vld,
  output logic [SDW-1:0] rx_dat,
  input  logic           rx_rdy,
  input  logic           spi_sclk_i,
  input  logic           spi_ss_i,
  input  logic           spi_sio_i,
  output logic           spi_sio_o,
  output logic           spi_sio_e,
  output logic           sts_ovf,
  output logic           sts_udf
);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SYN-1:0] mosi_q;

  sockit_spi_syn #(.SYN(SYN)) u_syn_sclk (
    .clk(clk), .rst(rst), .d_i(spi_sclk_i), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  sockit_spi_syn #(.SYN(SYN)) u_syn_ss (
    .clk(clk), .rst(rst), .d_i(spi_ss_i), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  slv_state_t     state_q, state_d;
  slv_cfg_t       cfg_q, cfg_d;
  logic [SDW-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d, rx_dat_q, rx_dat_d;
  logic [SDL-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic           rx_vld_q, rx_vld_d, ovf_q, ovf_d, udf_q, udf_d;

  logic           mosi, lead, trail, active, smp, sft, load;
  logic [SDW-1:0] rx_nxt, tx_nxt;

  function automatic logic [SDL-1:0] wrap_inc(input logic [SDL-1:0] c);
    return (c == SDL'(SDW-1)) ? '0 : c + 1'b1;
  endfunction

  assign mosi   = mosi_q[SYN-1];
  assign lead   = cfg_q.cpol ? sclk_fall : sclk_rise;
  assign trail  = cfg_q.cpol ? sclk_rise : sclk_fall;
  // An ss fall masks any sclk edge seen in the same cycle.
  assign active = (state_q == ACTIVE) && !ss_fall;
  assign smp    = active && (cfg_q.cpha ? trail : lead);
  assign sft    = active && (cfg_q.cpha ? lead : trail);
  assign load   = ((state_q == IDLE) && ss_rise && !cfg_cpha) ||
                  (sft && (cfg_q.cpha ? (tx_cnt_q == '0) : (tx_cnt_q == SDL'(SDW-1))));

  assign rx_nxt = cfg_q.lsb ? {mosi, rx_sr_q[SDW-1:1]} : {rx_sr_q[SDW-2:0], mosi};
  assign tx_nxt = cfg_q.lsb ? {1'b1, tx_sr_q[SDW-1:1]} : {tx_sr_q[SDW-2:0], 1'b1};

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    rx_sr_d  = rx_sr_q;
    rx_cnt_d = rx_cnt_q;
    tx_sr_d  = tx_sr_q;
    tx_cnt_d = tx_cnt_q;
    rx_dat_d = rx_dat_q;
    rx_vld_d = rx_vld_q & ~rx_rdy;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    if (state_q == IDLE) begin
      if (ss_rise) begin
        state_d  = ACTIVE;
        cfg_d    = '{cpol: cfg_cpol, cpha: cfg_cpha, lsb: cfg_lsb};
        rx_cnt_d = '0;
        tx_cnt_d = '0;
      end
    end else if (ss_fall) begin
      state_d = IDLE;
    end else begin
      if (smp) begin
        rx_sr_d  = rx_nxt;
        rx_cnt_d = wrap_inc(rx_cnt_q);
        if (rx_cnt_q == SDL'(SDW-1)) begin
          if (!rx_vld_q || rx_rdy) begin
            rx_dat_d = rx_nxt;
            rx_vld_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      if (sft) begin
        tx_cnt_d = wrap_inc(tx_cnt_q);
        tx_sr_d  = tx_nxt;
      end
    end
    if (load) begin
      tx_sr_d = tx_vld ? tx_dat : '1;
      udf_d   = ~tx_vld;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_q   <= '0;
      state_q  <= IDLE;
      cfg_q    <= '0;
      rx_sr_q  <= '0;
      rx_cnt_q <= '0;
      tx_sr_q  <= '1;
      tx_cnt_q <= '0;
      rx_dat_q <= '0;
      rx_vld_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      mosi_q   <= {mosi_q[SYN-2:0], spi_sio_i};
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      rx_sr_q  <= rx_sr_d;
      rx_cnt_q <= rx_cnt_d;
      tx_sr_q  <= tx_sr_d;
      tx_cnt_q <= tx_cnt_d;
      rx_dat_q <= rx_dat_d;
      rx_vld_q <= rx_vld_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign tx_rdy    = load & tx_vld;
  assign rx_vld    = rx_vld_q;
  assign rx_dat    = rx_dat_q;
  assign sts_ovf   = ovf_q;
  assign sts_udf   = udf_q;
  assign spi_sio_e = (state_q == ACTIVE);
  assign spi_sio_o = (state_q == ACTIVE) ? (cfg_q.lsb ? tx_sr_q[0] : tx_sr_q[SDW-1]) : 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_sockit_spi_slv.sv
// tb_sockit_spi_slv: directed bench acting as SPI master and stream endpoints.
// Revision 1.0
`default_nettype none

module tb_sockit_spi_slv;

  localparam int H = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb = 1'b0;
  logic       tx_vld, tx_rdy, rx_vld, rx_rdy = 1'b0;
  logic [7:0] tx_dat, rx_dat;
  logic       sclk = 1'b0, ss = 1'b0, mosi = 1'b0;
  logic       spi_sio_o, spi_sio_e, sts_ovf, sts_udf;

  int total = 0, bad = 0;
  int n_txrdy = 0, n_udf = 0, n_ovf = 0, rx_n = 0;
  logic [7:0] rx_log [64];
  logic [7:0] txq [8];
  int tx_head = 0, tx_tail = 0;
  logic [7:0] mo [4];
  logic [7:0] mi [4];

  always #5 clk = ~clk;

  sockit_spi_slv dut (
    .clk(clk), .rst(rst),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb(cfg_lsb),
    .tx_vld(tx_vld), .tx_dat(tx_dat), .tx_rdy(tx_rdy),
    .rx_vld(rx_vld), .rx_dat(rx_dat), .rx_rdy(rx_rdy),
    .spi_sclk_i(sclk), .spi_ss_i(ss), .spi_sio_i(mosi),
    .spi_sio_o(spi_sio_o), .spi_sio_e(spi_sio_e),
    .sts_ovf(sts_ovf), .sts_udf(sts_udf)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_rdy) n_txrdy++;
      if (sts_udf) n_udf++;
      if (sts_ovf) n_ovf++;
      if (rx_vld && rx_rdy) begin
        rx_log[rx_n] = rx_dat;
        rx_n++;
      end
    end
  end

  // Transmit word source: pops one queued word per accepted load.
  initial begin
    tx_vld = 1'b0;
    tx_dat = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_rdy) begin
        @(posedge clk);
        #1;
        tx_head++;
      end
      tx_vld = (tx_head != tx_tail);
      tx_dat = txq[tx_head % 8];
    end
  end

  task automatic push(input logic [7:0] d);
    txq[tx_tail % 8] = d;
    tx_tail++;
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic lsb);
    @(negedge clk);
    cfg_cpol = pol; cfg_cpha = pha; cfg_lsb = lsb;
    sclk = pol;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_sel();
    @(negedge clk);
    ss = 1'b1;
    #(2*H);
  endtask

  task automatic spi_bits(input int nbits);
    int w, bi;
    for (int b = 0; b < nbits; b++) begin
      w  = b / 8;
      bi = cfg_lsb ? (b % 8) : (7 - (b % 8));
      if (!cfg_cpha) begin
        mosi = mo[w][bi];
        #H; sclk = ~cfg_cpol; mi[w][bi] = spi_sio_o;
        #H; sclk = cfg_cpol;
      end else begin
        #H; sclk = ~cfg_cpol;
        #1; mosi = mo[w][bi];
        #(H-1); sclk = cfg_cpol; mi[w][bi] = spi_sio_o;
      end
    end
  endtask

  task automatic spi_desel();
    #H; ss = 1'b0;
    #(2*H);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (tx_rdy !== 1'b0) begin bad++; $display("FAIL rst_tx_rdy got=%b exp=0", tx_rdy); end
    total++; if (rx_vld !== 1'b0) begin bad++; $display("FAIL rst_rx_vld got=%b exp=0", rx_vld); end
    total++; if (rx_dat !== 8'h00) begin bad++; $display("FAIL rst_rx_dat got=%h exp=00", rx_dat); end
    total++; if (spi_sio_e !== 1'b0) begin bad++; $display("FAIL rst_sio_e got=%b exp=0", spi_sio_e); end
    total++; if (spi_sio_o !== 1'b1) begin bad++; $display("FAIL rst_sio_o got=%b exp=1", spi_sio_o); end
    total++; if ({sts_ovf, sts_udf} !== 2'b00) begin bad++; $display("FAIL rst_sts got=%b exp=00", {sts_ovf, sts_udf}); end
    rst = 1'b0;
    @(posedge clk); #1 rx_rdy = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mode0();
    int b_tx, b_rx;
    push(8'h3C);
    set_mode(1'b0, 1'b0, 1'b0);
    b_tx = n_txrdy; b_rx = rx_n; mo[0] = 8'hA5;
    spi_sel();
    total++; if (n_txrdy - b_tx !== 1) begin bad++; $display("FAIL m0_txrdy_at_sel got=%0d exp=1", n_txrdy - b_tx); end
    total++; if (spi_sio_e !== 1'b1) begin bad++; $display("FAIL m0_sio_e got=%b exp=1", spi_sio_e); end
    spi_bits(8);
    spi_desel();
    total++; if (n_txrdy - b_tx !== 1) begin bad++; $display("FAIL m0_txrdy_total got=%0d exp=1", n_txrdy - b_tx); end
    total++; if (rx_n - b_rx !== 1) begin bad++; $display("FAIL m0_rx_count got=%0d exp=1", rx_n - b_rx); end
    total++; if (rx_log[rx_n-1] !== 8'hA5) begin bad++; $display("FAIL m0_rx_dat got=%h exp=a5", rx_log[rx_n-1]); end
    total++; if (mi[0] !== 8'h3C) begin bad++; $display("FAIL m0_miso got=%h exp=3c", mi[0]); end
  endtask

  task automatic test_mode3_b2b();
    int b_tx, b_rx;
    push(8'hF0); push(8'h0F);
    set_mode(1'b1, 1'b1, 1'b1);
    b_tx = n_txrdy; b_rx = rx_n; mo[0] = 8'h01; mo[1] = 8'h80;
    spi_sel();
    total++; if (n_txrdy - b_tx !== 0) begin bad++; $display("FAIL m3_txrdy_at_sel got=%0d exp=0", n_txrdy - b_tx); end
    spi_bits(16);
    spi_desel();
    total++; if (n_txrdy - b_tx !== 2) begin bad++; $display("FAIL m3_txrdy_total got=%0d exp=2", n_txrdy - b_tx); end
    total++; if (rx_n - b_rx !== 2) begin bad++; $display("FAIL m3_rx_count got=%0d exp=2", rx_n - b_rx); end
    total++; if (rx_log[b_rx] !== 8'h01) begin bad++; $display("FAIL m3_rx0 got=%h exp=01", rx_log[b_rx]); end
    total++; if (rx_log[b_rx+1] !== 8'h80) begin bad++; $display("FAIL m3_rx1 got=%h exp=80", rx_log[b_rx+1]); end
    total++; if (mi[0] !== 8'hF0) begin bad++; $display("FAIL m3_miso0 got=%h exp=f0", mi[0]); end
    total++; if (mi[1] !== 8'h0F) begin bad++; $display("FAIL m3_miso1 got=%h exp=0f", mi[1]); end
  endtask

  task automatic test_underflow();
    int b_udf, b_tx;
    set_mode(1'b0, 1'b1, 1'b0);
    b_udf = n_udf; b_tx = n_txrdy; mo[0] = 8'h12; mo[1] = 8'h34;
    spi_sel(); spi_bits(16); spi_desel();
    total++; if (mi[0] !== 8'hFF) begin bad++; $display("FAIL udf_miso0 got=%h exp=ff", mi[0]); end
    total++; if (mi[1] !== 8'hFF) begin bad++; $display("FAIL udf_miso1 got=%h exp=ff", mi[1]); end
    total++; if (n_udf - b_udf !== 2) begin bad++; $display("FAIL udf_pulses got=%0d exp=2", n_udf - b_udf); end
    total++; if (n_txrdy - b_tx !== 0) begin bad++; $display("FAIL udf_txrdy got=%0d exp=0", n_txrdy - b_tx); end
  endtask

  task automatic test_overflow();
    int b_ovf, b_rx;
    set_mode(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 rx_rdy = 1'b0;
    b_ovf = n_ovf; b_rx = rx_n; mo[0] = 8'h11; mo[1] = 8'h22;
    spi_sel(); spi_bits(16); spi_desel();
    total++; if (rx_vld !== 1'b1) begin bad++; $display("FAIL ovf_rx_vld got=%b exp=1", rx_vld); end
    total++; if (rx_dat !== 8'h11) begin bad++; $display("FAIL ovf_rx_dat got=%h exp=11", rx_dat); end
    total++; if (n_ovf - b_ovf !== 1) begin bad++; $display("FAIL ovf_pulses got=%0d exp=1", n_ovf - b_ovf); end
    @(posedge clk); #1 rx_rdy = 1'b1;
    @(posedge clk); #1;
    total++; if (rx_vld !== 1'b0) begin bad++; $display("FAIL ovf_vld_drop got=%b exp=0", rx_vld); end
    total++; if (rx_n - b_rx !== 1) begin bad++; $display("FAIL ovf_rx_count got=%0d exp=1", rx_n - b_rx); end
    total++; if (rx_log[b_rx] !== 8'h11) begin bad++; $display("FAIL ovf_rx_taken got=%h exp=11", rx_log[b_rx]); end
  endtask

  task automatic test_abort();
    int b_rx;
    set_mode(1'b0, 1'b0, 1'b0);
    b_rx = rx_n; mo[0] = 8'hFF;
    spi_sel(); spi_bits(5);
    @(negedge clk); ss = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (spi_sio_e !== 1'b0) begin bad++; $display("FAIL abort_sio_e got=%b exp=0", spi_sio_e); end
    total++; if (spi_sio_o !== 1'b1) begin bad++; $display("FAIL abort_sio_o got=%b exp=1", spi_sio_o); end
    #(2*H);
    total++; if (rx_n - b_rx !== 0) begin bad++; $display("FAIL abort_no_rx got=%0d exp=0", rx_n - b_rx); end
    mo[0] = 8'h5A;
    spi_sel(); spi_bits(8); spi_desel();
    total++; if (rx_n - b_rx !== 1) begin bad++; $display("FAIL abort_next_count got=%0d exp=1", rx_n - b_rx); end
    total++; if (rx_log[rx_n-1] !== 8'h5A) begin bad++; $display("FAIL abort_next_dat got=%h exp=5a", rx_log[rx_n-1]); end
  endtask

  task automatic test_async_rst();
    int b_rx;
    set_mode(1'b1, 1'b0, 1'b0);
    @(posedge clk); #1 rx_rdy = 1'b0;
    mo[0] = 8'h77;
    spi_sel(); spi_bits(8); spi_desel();
    total++; if (rx_dat !== 8'h77) begin bad++; $display("FAIL ar_pre_dat got=%h exp=77", rx_dat); end
    mo[0] = 8'h00;
    spi_sel(); spi_bits(3);
    total++; if (spi_sio_e !== 1'b1) begin bad++; $display("FAIL ar_pre_sio_e got=%b exp=1", spi_sio_e); end
    #37 rst = 1'b1;
    #1;
    total++; if (rx_vld !== 1'b0) begin bad++; $display("FAIL ar_rx_vld got=%b exp=0", rx_vld); end
    total++; if (rx_dat !== 8'h00) begin bad++; $display("FAIL ar_rx_dat got=%h exp=00", rx_dat); end
    total++; if (spi_sio_e !== 1'b0) begin bad++; $display("FAIL ar_sio_e got=%b exp=0", spi_sio_e); end
    total++; if (spi_sio_o !== 1'b1) begin bad++; $display("FAIL ar_sio_o got=%b exp=1", spi_sio_o); end
    total++; if ({tx_rdy, sts_ovf, sts_udf} !== 3'b000) begin bad++; $display("FAIL ar_pulses got=%b exp=000", {tx_rdy, sts_ovf, sts_udf}); end
    ss = 1'b0; sclk = cfg_cpol; mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    rx_rdy = 1'b1;
    repeat (8) @(negedge clk);
    push(8'h96);
    b_rx = rx_n; mo[0] = 8'hC3;
    repeat (2) @(negedge clk);
    spi_sel(); spi_bits(8); spi_desel();
    total++; if (rx_n - b_rx !== 1) begin bad++; $display("FAIL ar_next_count got=%0d exp=1", rx_n - b_rx); end
    total++; if (rx_log[rx_n-1] !== 8'hC3) begin bad++; $display("FAIL ar_next_dat got=%h exp=c3", rx_log[rx_n-1]); end
    total++; if (mi[0] !== 8'h96) begin bad++; $display("FAIL ar_next_miso got=%h exp=96", mi[0]); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3_b2b();
    test_underflow();
    test_overflow();
    test_abort();
    test_async_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sockit_spi_slv.md
Name: sockit_spi_slv

Overview:
- SPI slave (target) endpoint, the far end of the link driven by the sockit_spi master.
- Oversamples SCLK, SS and MOSI on the local system clock.
- Deserializes MOSI into SDW-bit receive words, and serializes transmit words onto MISO.
- Exchanges words with local logic over valid/ready streams.
- Used for loopback verification of the master and as a standalone SPI peripheral port.

Parameters:
- SDW, 8, serial data word width (bits per transfer word), at least 2.
- SYN, 2, synchronizer depth for spi_sclk_i, spi_ss_i and spi_sio_i; at least 2.
- SDL, $clog2(SDW), bit counter width.

Ports:
- clk  input  1  system clock; all logic is on this single clock.
- rst  input  1  reset; asynchronous, active-high.
- cfg_cpol  input  1  clock polarity, the SCLK idle level.
- cfg_cpha  input  1  clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
- cfg_lsb  input  1  1 = LSB first, 0 = MSB first.
- tx_vld  input  1  transmit word valid.
- tx_dat  input  SDW  transmit word.
- tx_rdy  output  1  transmit word accepted (one-cycle pulse at each load event).
- rx_vld  output  1  receive word valid.
- rx_dat  output  SDW  receive word.
- rx_rdy  input  1  receive word consumed.
- spi_sclk_i  input  1  serial clock from the master.
- spi_ss_i  input  1  slave select, active-high (inverter sits at the pad).
- spi_sio_i  input  1  MOSI.
- spi_sio_o  output  1  MISO data.
- spi_sio_e  output  1  MISO output enable.
- sts_ovf  output  1  one-cycle pulse: a received word was dropped.
- sts_udf  output  1  one-cycle pulse: a load event occurred with tx_vld low.

Behaviour:
- Reset values (asynchronous assert):
  - tx_rdy, rx_vld, spi_sio_e, sts_ovf, sts_udf = 0.
  - rx_dat = 0; spi_sio_o = 1.
  - State IDLE; both counters = 0; synchronizers cleared to 0.
- Input path:
  - sclk, ss and mosi each pass through SYN flops.
  - One extra flop on sclk and ss gives rise/fall detection.
  - Latency from a pin change to the internal event is SYN+1 clk cycles.
  - Supported SCLK frequency is at most clk/8. Faster SCLK is out of spec; behaviour is undefined but the block must not lock up.
- Edge naming:
  - Leading edge = sclk transition away from cfg_cpol; trailing edge = transition back.
  - Sample edge = leading if cpha=0, else trailing.
  - Shift edge = the other one.
- Configuration: cfg_* are captured into a local register on the ss rising event and held constant for the whole selection.
- State machine:
  - IDLE -> ACTIVE on ss rise: clear rx_cnt and tx_cnt, set spi_sio_e = 1; if cpha=0, perform a load event.
  - ACTIVE -> IDLE on ss fall: spi_sio_e = 0, spi_sio_o = 1.
  - A partial receive word is discarded on ss fall; no rx_vld, no pulse.
  - SCLK edges in IDLE are ignored.
- Receive:
  - On each sample edge, shift the synchronized MOSI into rx_sr, left when lsb=0 and right when lsb=1; rx_cnt increments modulo SDW.
  - When rx_cnt wraps (the SDW-th sample), the word is completed:
    - if rx_vld=0 or rx_rdy=1 that cycle, copy to rx_dat and set rx_vld = 1;
    - otherwise drop the new word, keep the old rx_dat and pulse sts_ovf.
  - rx_vld clears on rx_vld&rx_rdy unless a new word completes in the same cycle; in that case it stays 1 with the new data.
- Transmit:
  - spi_sio_o = tx_sr MSB (lsb=0) or tx_sr LSB (lsb=1).
  - On each shift edge tx_cnt increments modulo SDW.
  - A load event replaces a shift at these points:
    - cpha=0: at ss rise and on shift edges where tx_cnt==SDW-1;
    - cpha=1: on shift edges where tx_cnt==0.
  - Load event with tx_vld=1: tx_sr = tx_dat, tx_rdy pulses for 1 cycle.
  - Load event with tx_vld=0: tx_sr = all ones, sts_udf pulses.
  - tx_rdy is never asserted outside load events.
- Simultaneous events:
  - ss fall in the same cycle as a sample edge: ss fall wins; the edge is ignored.
  - ss fall and ss rise are never simultaneous, because of the synchronizer.
- Reset mid-transfer aborts everything: outputs return to reset values and no stream handshakes are issued.

Decomposition:
- sockit_spi_pkg gains:
  - typedef slv_cfg_t, a packed struct {cpol, cpha, lsb} used for the captured configuration;
  - an enum slv_state_t {IDLE, ACTIVE}.
- One natural sub-module: sockit_spi_syn, a parameterized SYN-stage synchronizer plus rise/fall detector. It is instantiated for sclk and ss; mosi uses the synchronizer only.

Test Plan:
- Mode 0, MSB first, SDW=8: master sends 0xA5 while tx_dat=0x3C is pending -> rx_dat=0xA5 with one rx_vld; master receives 0x3C; tx_rdy pulses exactly once, at ss rise.
- Mode 3, LSB first: master sends 0x01, 0x80 back-to-back with tx words 0xF0, 0x0F -> rx sequence 0x01, 0x80; MISO sequence 0xF0, 0x0F; tx_rdy pulses on the first leading edge of each word.
- Underflow: tx_vld=0 with mode 1 and a 2-word transfer -> master reads 0xFF, 0xFF; sts_udf pulses twice.
- Overflow: rx_rdy held 0 across 2 words 0x11, 0x22 -> rx_dat stays 0x11; sts_ovf pulses once; after rx_rdy, rx_vld drops.
- Abort: ss deasserted after 5 of 8 bits -> no rx_vld; spi_sio_e=0 within SYN+2 cycles; the next selection receives 0x5A correctly.
- Async rst asserted mid-word in mode 2 -> all outputs reach reset values immediately; the following transfer 0xC3 completes normally.
